// File: rtl/sao_stat_buf.sv
// N-deep snapshot FIFO between the SAO statistics collector and the DCI stage.
// Optional macro SAO_STAT_BUF_FALLTHROUGH_EN: an empty buffer passes a push straight to rd_* in the same cycle.
module sao_stat_buf #(
  parameter int ctu_x_len        = 9,
  parameter int ctu_y_len        = 9,
  parameter int diff_clip_bit    = 4,
  parameter int n_category       = 4,
  parameter int n_category_bo    = 8,
  parameter int num_pix_CTU_log2 = 5,
  parameter int num_accu_len     = num_pix_CTU_log2*2-1,
  parameter int n_eo_type        = 4,
  parameter int DEPTH            = 2
) (
  input  logic                                                    clk_slow,
  input  logic                                                    arst_n,
  input  logic                                                    rst_n,
  input  logic                                                    wr_valid,
  output logic                                                    wr_ready,
  input  logic [1:0]                                              wr_cidx,
  input  logic [ctu_x_len-1:0]                                    wr_ctu_x,
  input  logic [ctu_y_len-1:0]                                    wr_ctu_y,
  input  logic                                                    wr_left_merge,
  input  logic                                                    wr_up_merge,
  input  logic [4:0]                                              wr_cand_bo,
  input  logic [n_eo_type-1:0][n_category-1:0][num_accu_len+diff_clip_bit:0] wr_sum_eo,
  input  logic [n_eo_type-1:0][n_category-1:0][num_accu_len:0]   wr_num_eo,
  input  logic [n_category_bo-1:0][num_accu_len+diff_clip_bit:0] wr_sum_bo,
  input  logic [n_category_bo-1:0][num_accu_len:0]               wr_num_bo,
  output logic                                                    rd_valid,
  input  logic                                                    rd_ready,
  output logic [1:0]                                              rd_cidx,
  output logic [ctu_x_len-1:0]                                    rd_ctu_x,
  output logic [ctu_y_len-1:0]                                    rd_ctu_y,
  output logic                                                    rd_left_merge,
  output logic                                                    rd_up_merge,
  output logic [4:0]                                              rd_cand_bo,
  output logic [n_eo_type-1:0][n_category-1:0][num_accu_len+diff_clip_bit:0] rd_sum_eo,
  output logic [n_eo_type-1:0][n_category-1:0][num_accu_len:0]   rd_num_eo,
  output logic [n_category_bo-1:0][num_accu_len+diff_clip_bit:0] rd_sum_bo,
  output logic [n_category_bo-1:0][num_accu_len:0]               rd_num_bo,
  output logic [$clog2(DEPTH):0]                                  level,
  output logic                                                    err_cidx
);
  localparam int SW = num_accu_len + diff_clip_bit + 1;
  localparam int NW = num_accu_len + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  // Sums are two's complement bit patterns; they are carried untouched.
  typedef struct packed {
    logic [1:0]                                    cidx;
    logic [ctu_x_len-1:0]                          x;
    logic [ctu_y_len-1:0]                          y;
    logic                                          lm;
    logic                                          um;
    logic [4:0]                                    bo;
    logic [n_eo_type-1:0][n_category-1:0][SW-1:0] seo;
    logic [n_eo_type-1:0][n_category-1:0][NW-1:0] neo;
    logic [n_category_bo-1:0][SW-1:0]             sbo;
    logic [n_category_bo-1:0][NW-1:0]             nbo;
  } ent_t;

  ent_t           mem [DEPTH];
  ent_t           wr_ent, head, rd_ent;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [LW-1:0]  level_q;
  logic           acc, push, pop;

  assign wr_ent = '{cidx: wr_cidx, x: wr_ctu_x, y: wr_ctu_y, lm: wr_left_merge,
                    um: wr_up_merge, bo: wr_cand_bo, seo: wr_sum_eo, neo: wr_num_eo,
                    sbo: wr_sum_bo, nbo: wr_num_bo};

  assign wr_ready = (level_q != LW'(DEPTH));
  assign acc      = wr_valid && wr_ready;
  assign push     = acc && (wr_cidx != 2'd3);

`ifdef SAO_STAT_BUF_FALLTHROUGH_EN
  logic bypass;
  assign bypass   = (level_q == '0) && push;
  assign rd_valid = (level_q != '0) || bypass;
  assign head     = bypass ? wr_ent : mem[rd_ptr];
`else
  assign rd_valid = (level_q != '0);
  assign head     = mem[rd_ptr];
`endif

  // A bypassed push that is popped at once still walks both pointers, so level stays 0.
  assign pop = rd_valid && rd_ready;

  always_ff @(posedge clk_slow or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      err_cidx <= 1'b0;
    end else if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      err_cidx <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (acc && wr_cidx == 2'd3) err_cidx <= 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_slow) begin
    if (push) mem[wr_ptr] <= wr_ent;
  end

  assign rd_ent        = rd_valid ? head : '0;
  assign rd_cidx       = rd_ent.cidx;
  assign rd_ctu_x      = rd_ent.x;
  assign rd_ctu_y      = rd_ent.y;
  assign rd_left_merge = rd_ent.lm;
  assign rd_up_merge   = rd_ent.um;
  assign rd_cand_bo    = rd_ent.bo;
  assign rd_sum_eo     = rd_ent.seo;
  assign rd_num_eo     = rd_ent.neo;
  assign rd_sum_bo     = rd_ent.sbo;
  assign rd_num_bo     = rd_ent.nbo;
  assign level         = level_q;
endmodule

// File: tb/tb_sao_stat_buf.sv
// Randomized + directed bench for sao_stat_buf against a queue-based FIFO model.
module tb_sao_stat_buf;
  localparam int DEPTH = 2;
  localparam int SW = 14;
  localparam int NW = 10;
`ifdef SAO_STAT_BUF_FALLTHROUGH_EN
  localparam bit FT = 1'b1;
`else
  localparam bit FT = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]              cidx;
    logic [8:0]              x;
    logic [8:0]              y;
    logic                    lm;
    logic                    um;
    logic [4:0]              bo;
    logic [3:0][3:0][SW-1:0] seo;
    logic [3:0][3:0][NW-1:0] neo;
    logic [7:0][SW-1:0]      sbo;
    logic [7:0][NW-1:0]      nbo;
  } ent_t;

  logic clk_slow = 1'b0, arst_n = 1'b0, rst_n = 1'b1;
  logic wr_valid = 1'b0, wr_ready, rd_valid, rd_ready = 1'b0, err_cidx;
  logic [1:0] wr_cidx = '0, rd_cidx;
  logic [8:0] wr_ctu_x = '0, wr_ctu_y = '0, rd_ctu_x, rd_ctu_y;
  logic wr_left_merge = 1'b0, wr_up_merge = 1'b0, rd_left_merge, rd_up_merge;
  logic [4:0] wr_cand_bo = '0, rd_cand_bo;
  logic [3:0][3:0][SW-1:0] wr_sum_eo = '0, rd_sum_eo;
  logic [3:0][3:0][NW-1:0] wr_num_eo = '0, rd_num_eo;
  logic [7:0][SW-1:0] wr_sum_bo = '0, rd_sum_bo;
  logic [7:0][NW-1:0] wr_num_bo = '0, rd_num_bo;
  logic [1:0] level;

  always #5 clk_slow = ~clk_slow;

  sao_stat_buf #(.DEPTH(DEPTH)) dut (
    .clk_slow(clk_slow), .arst_n(arst_n), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_cidx(wr_cidx),
    .wr_ctu_x(wr_ctu_x), .wr_ctu_y(wr_ctu_y), .wr_left_merge(wr_left_merge),
    .wr_up_merge(wr_up_merge), .wr_cand_bo(wr_cand_bo), .wr_sum_eo(wr_sum_eo),
    .wr_num_eo(wr_num_eo), .wr_sum_bo(wr_sum_bo), .wr_num_bo(wr_num_bo),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_cidx(rd_cidx),
    .rd_ctu_x(rd_ctu_x), .rd_ctu_y(rd_ctu_y), .rd_left_merge(rd_left_merge),
    .rd_up_merge(rd_up_merge), .rd_cand_bo(rd_cand_bo), .rd_sum_eo(rd_sum_eo),
    .rd_num_eo(rd_num_eo), .rd_sum_bo(rd_sum_bo), .rd_num_bo(rd_num_bo),
    .level(level), .err_cidx(err_cidx)
  );

  int   n_cmp = 0, n_bad = 0;
  ent_t q[$];
  logic m_err = 1'b0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ent_t rnd_ent(input logic [1:0] cidx, input logic [8:0] x);
    ent_t e;
    e.cidx = cidx; e.x = x; e.y = 9'($urandom);
    e.lm = 1'($urandom); e.um = 1'($urandom); e.bo = 5'($urandom);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        e.seo[i][j] = SW'($urandom);
        e.neo[i][j] = NW'($urandom);
      end
    for (int k = 0; k < 8; k++) begin
      e.sbo[k] = SW'($urandom);
      e.nbo[k] = NW'($urandom);
    end
    return e;
  endfunction

  // One clock: drive at negedge, check settled outputs vs model, then advance model at posedge.
  task automatic cyc(input logic v, input ent_t e, input logic rr, input logic rs);
    logic acc, push, byp, ev, pop;
    ent_t eh;
    wr_valid = v; wr_cidx = e.cidx; wr_ctu_x = e.x; wr_ctu_y = e.y;
    wr_left_merge = e.lm; wr_up_merge = e.um; wr_cand_bo = e.bo;
    wr_sum_eo = e.seo; wr_num_eo = e.neo; wr_sum_bo = e.sbo; wr_num_bo = e.nbo;
    rd_ready = rr; rst_n = rs;
    acc  = v && (q.size() != DEPTH);
    push = acc && (e.cidx != 2'd3);
    byp  = FT && (q.size() == 0) && push;
    ev   = (q.size() != 0) || byp;
    eh   = (q.size() != 0) ? q[0] : (byp ? e : '0);
    #1;
    chk("rd_valid", rd_valid, ev);
    chk("level", level, q.size());
    chk("wr_ready", wr_ready, q.size() != DEPTH);
    chk("err_cidx", err_cidx, m_err);
    chk("rd_hdr", {rd_cidx, rd_ctu_x, rd_ctu_y, rd_left_merge, rd_up_merge, rd_cand_bo},
        {eh.cidx, eh.x, eh.y, eh.lm, eh.um, eh.bo});
    chk("rd_sum_eo", rd_sum_eo, eh.seo);
    chk("rd_num_eo", rd_num_eo, eh.neo);
    chk("rd_bo", {rd_sum_bo, rd_num_bo}, {eh.sbo, eh.nbo});
    pop = ev && rr;
    @(posedge clk_slow);
    if (!rs) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      if (push) q.push_back(e);
      if (pop) void'(q.pop_front());
      if (acc && e.cidx == 2'd3) m_err = 1'b1;
    end
    @(negedge clk_slow);
  endtask

  ent_t e0, ey, ecb, ecr;

  initial begin
    e0 = '0;
    #12 arst_n = 1'b1;
    @(negedge clk_slow);
    // reset / idle
    cyc(1'b0, e0, 1'b0, 1'b1);
    cyc(1'b0, e0, 1'b1, 1'b1);

    // single Y push, signed and max-count fields
    ey = rnd_ent(2'd0, 9'd3);
    ey.y = 9'd5; ey.seo[1][2] = SW'(-37); ey.nbo[7] = 10'd511;
    cyc(1'b1, ey, 1'b0, 1'b1);
    cyc(1'b0, e0, 1'b0, 1'b1);
    chk("seo12", rd_sum_eo[1][2], 14'h3fdb);
    chk("nbo7", rd_num_bo[7], 10'd511);
    chk("ctu_y", rd_ctu_y, 9'd5);
    cyc(1'b0, e0, 1'b0, 1'b0);

    // Y, Cb, Cr back-to-back; Cr stalls until a pop frees a slot
    ey = rnd_ent(2'd0, 9'd10); ecb = rnd_ent(2'd1, 9'd11); ecr = rnd_ent(2'd2, 9'd12);
    cyc(1'b1, ey, 1'b0, 1'b1);
    cyc(1'b1, ecb, 1'b0, 1'b1);
    cyc(1'b1, ecr, 1'b0, 1'b1);
    chk("full_lvl", level, 2'd2);
    cyc(1'b1, ecr, 1'b1, 1'b1);
    cyc(1'b1, ecr, 1'b1, 1'b1);
    cyc(1'b0, e0, 1'b1, 1'b1);
    cyc(1'b0, e0, 1'b1, 1'b1);

    // streaming push+pop, pointers wrap
    for (int i = 0; i < 6; i++) cyc(1'b1, rnd_ent(2'($urandom_range(0, 2)), 9'(i)), 1'b1, 1'b1);
    cyc(1'b0, e0, 1'b1, 1'b1);
    cyc(1'b0, e0, 1'b1, 1'b1);

    // illegal cIdx, then sync clear
    cyc(1'b1, rnd_ent(2'd0, 9'd20), 1'b0, 1'b1);
    cyc(1'b1, rnd_ent(2'd3, 9'd21), 1'b0, 1'b1);
    cyc(1'b0, e0, 1'b0, 1'b1);
    chk("err_set", err_cidx, 1'b1);
    cyc(1'b0, e0, 1'b0, 1'b0);
    cyc(1'b0, e0, 1'b0, 1'b1);

    if (FT) begin
      cyc(1'b1, rnd_ent(2'd0, 9'd7), 1'b1, 1'b1);
      cyc(1'b0, e0, 1'b0, 1'b1);
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [1:0] c;
      c = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      cyc(1'($urandom_range(0, 9) < 7), rnd_ent(c, 9'($urandom)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 59) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
